issue_hazard_ctrl: RTL and testbench

- Decode-to-execute issue controller that sits in front of the 8-entry register-invalid scoreboard.
- Checks the source and destination registers of the decoded instruction against the scoreboard's per-register pending-write counts, and stalls decode on hazards.
- On each issue, drives the scoreboard's update inputs (write strobe, load flag, destination address).
- Provides a flush drain window, a stall statistic counter and a hazard watchdog.

---
 rtl/issue_hazard_ctrl_if.sv | 48 ++++
 rtl/issue_hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_issue_hazard_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/issue_hazard_ctrl_if.sv
// Decode/execute/scoreboard signal bundle for issue_hazard_ctrl.
//
// Decode side:     id_valid, id_rs_adr/id_rs_used, id_rt_adr/id_rt_used, id_rd_adr,
//                  id_regwrite, id_is_load
// Execute side:    ex_ready, flush
// Scoreboard side: register_invalid (pending-write count per register, 0 = valid),
//                  regwrite_cur/from_main_mem/regwrite_adr_id (update strobe + payload)
// Controller out:  issue, stall_id, state_o, stall_cycles, hazard_timeout
//
// The slave modport is the controller's view; master is the surrounding pipeline.
interface issue_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic                  id_valid;
    logic [2:0]            id_rs_adr;
    logic                  id_rs_used;
    logic [2:0]            id_rt_adr;
    logic                  id_rt_used;
    logic [2:0]            id_rd_adr;
    logic                  id_regwrite;
    logic                  id_is_load;
    logic                  ex_ready;
    logic                  flush;
    logic [7:0][2:0]       register_invalid;

    logic                  issue;
    logic                  stall_id;
    logic                  regwrite_cur;
    logic                  from_main_mem;
    logic [2:0]            regwrite_adr_id;
    logic [1:0]            state_o;
    logic [CNT_W-1:0]      stall_cycles;
    logic                  hazard_timeout;

    modport master (
        output id_valid, id_rs_adr, id_rs_used, id_rt_adr, id_rt_used, id_rd_adr,
        output id_regwrite, id_is_load, ex_ready, flush, register_invalid,
        input  issue, stall_id, regwrite_cur, from_main_mem, regwrite_adr_id,
        input  state_o, stall_cycles, hazard_timeout
    );

    modport slave (
        input  id_valid, id_rs_adr, id_rs_used, id_rt_adr, id_rt_used, id_rd_adr,
        input  id_regwrite, id_is_load, ex_ready, flush, register_invalid,
        output issue, stall_id, regwrite_cur, from_main_mem, regwrite_adr_id,
        output state_o, stall_cycles, hazard_timeout
    );
endinterface

// File: rtl/issue_hazard_ctrl.sv
// Decode-to-execute issue controller in front of the 8-entry register-invalid scoreboard.
//
// Holds the decoded instruction while any source it reads has a pending write, or while its
// destination counter is saturated (7), and drives the scoreboard update strobe on issue.
// A flush opens a drain window of DRAIN_CYCLES cycles during which nothing issues.
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - issue_hazard_ctrl_if.slave: decode inputs, ex_ready/flush, register_invalid,
//           comb outputs issue/stall_id/regwrite_cur/from_main_mem/regwrite_adr_id and
//           registered outputs state_o/stall_cycles/hazard_timeout
module issue_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned TIMEOUT      = 255,
    parameter int unsigned CNT_W        = 16
) (
    input logic                clk,
    input logic                reset,
    issue_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StHold  = 2'd1,
        StDrain = 2'd2
    } state_e;

    localparam logic [3:0]       DrainLoad  = 4'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntMax     = '1;
    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

    state_e           state_q, state_d;
    logic [3:0]       drain_q, drain_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             timeout_q, timeout_d;

    logic rs_haz, rt_haz, sat_haz, hazard;
    logic issue, stall_id, regwrite_cur;

    // ------------------------------------------------------------------
    // Hazard detection. Register 0 is an ordinary register here.
    // ------------------------------------------------------------------
    always_comb begin
        rs_haz  = bus.id_rs_used && (bus.register_invalid[bus.id_rs_adr] != 3'd0);
        rt_haz  = bus.id_rt_used && (bus.register_invalid[bus.id_rt_adr] != 3'd0);
        // One more pending write would overflow the 3-bit scoreboard counter.
        sat_haz = bus.id_regwrite && (bus.register_invalid[bus.id_rd_adr] == 3'd7);
        hazard  = rs_haz || rt_haz || sat_haz;
    end

    // ------------------------------------------------------------------
    // Combinational issue / stall / scoreboard update. Forced low in reset so the
    // scoreboard never sees a strobe while the controller is being cleared.
    // ------------------------------------------------------------------
    always_comb begin
        issue        = !reset && (state_q == StRun) && bus.id_valid && !hazard &&
                       bus.ex_ready && !bus.flush;
        stall_id     = !reset && ((bus.id_valid && !issue) || (state_q == StDrain));
        regwrite_cur = issue && bus.id_regwrite;
    end

    assign bus.issue           = issue;
    assign bus.stall_id        = stall_id;
    assign bus.regwrite_cur    = regwrite_cur;
    assign bus.from_main_mem   = regwrite_cur && bus.id_is_load;
    assign bus.regwrite_adr_id = regwrite_cur ? bus.id_rd_adr : 3'd0;

    // ------------------------------------------------------------------
    // FSM next state, drain/hold counters and the sticky watchdog.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        hold_d    = hold_q;
        timeout_d = timeout_q;

        case (state_q)
            StRun: begin
                if (bus.flush) begin
                    state_d = StDrain;
                    drain_d = DrainLoad;
                end else if (bus.id_valid && hazard) begin
                    state_d = StHold;
                    hold_d  = CNT_W'(1);
                end
            end

            StHold: begin
                if (bus.flush) begin
                    state_d = StDrain;
                    drain_d = DrainLoad;
                    hold_d  = '0;
                end else if (!bus.id_valid || !hazard) begin
                    // Leaving HOLD costs one bubble: the issue happens in RUN next cycle.
                    state_d = StRun;
                    hold_d  = '0;
                end else begin
                    if (hold_q != CntMax) begin
                        hold_d = hold_q + CNT_W'(1);
                    end
                    // hold_q counts HOLD cycles already spent, this one included.
                    if (hold_q >= TimeoutVal) begin
                        timeout_d = 1'b1;
                    end
                end
            end

            StDrain: begin
                if (bus.flush) begin
                    drain_d = DrainLoad;
                end else if (drain_q == 4'd0) begin
                    state_d = StRun;
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end

            default: begin
                state_d = StRun;
                drain_d = '0;
                hold_d  = '0;
            end
        endcase
    end

    // Stalled-cycle statistic: counts in every state, saturates instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.id_valid && !issue && (stall_cnt_q != CntMax)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StRun;
            drain_q     <= '0;
            hold_q      <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            hold_q      <= hold_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.state_o        = state_q;
    assign bus.stall_cycles   = stall_cnt_q;
    assign bus.hazard_timeout = timeout_q;

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Self-checking bench for issue_hazard_ctrl (DRAIN_CYCLES=3, TIMEOUT=4, CNT_W=16).
// Each driven cycle pushes its hand-computed expectation into a queue; a negedge monitor
// pops and compares. An expected value of -1 means "not checked this cycle".
module tb_issue_hazard_ctrl;

    localparam int unsigned CntW = 16;

    logic clk;
    logic reset;

    issue_hazard_ctrl_if #(.CNT_W(CntW)) bus ();

    issue_hazard_ctrl #(
        .DRAIN_CYCLES(3),
        .TIMEOUT     (4),
        .CNT_W       (CntW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string nm;
        int    iss, stl, rwc, fmm, adr, st, stc, hto;
    } exp_t;

    exp_t            exp_q[$];
    exp_t            mon_e;
    int              n_chk  = 0;
    int              n_fail = 0;
    logic            rst_next = 1'b1;
    logic            use_model = 1'b0;
    logic [7:0][2:0] ri = '0;
    logic [2:0]      sb_cnt [8];

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input int expv);
        if (expv < 0) return;
        n_chk++;
        if (act !== 32'(expv)) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, expv);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk(mon_e.nm, "issue",          32'(bus.issue),           mon_e.iss);
            chk(mon_e.nm, "stall_id",       32'(bus.stall_id),        mon_e.stl);
            chk(mon_e.nm, "regwrite_cur",   32'(bus.regwrite_cur),    mon_e.rwc);
            chk(mon_e.nm, "from_main_mem",  32'(bus.from_main_mem),   mon_e.fmm);
            chk(mon_e.nm, "regwrite_adr",   32'(bus.regwrite_adr_id), mon_e.adr);
            chk(mon_e.nm, "state",          32'(bus.state_o),         mon_e.st);
            chk(mon_e.nm, "stall_cycles",   32'(bus.stall_cycles),    mon_e.stc);
            chk(mon_e.nm, "hazard_timeout", 32'(bus.hazard_timeout),  mon_e.hto);
        end
    end

    // One clock cycle: update the scoreboard model from last cycle's strobe, drive inputs
    // just after the edge, then queue the expectation for this cycle.
    task automatic cyc(input string nm, input logic v, input logic rsu, input logic [2:0] rs,
                       input logic rtu, input logic [2:0] rt, input logic [2:0] rd,
                       input logic rw, input logic ld, input logic exr, input logic fl,
                       input int e_iss, input int e_stl, input int e_rwc, input int e_fmm,
                       input int e_adr, input int e_st, input int e_stc, input int e_hto);
        logic       rwc_s;
        logic [2:0] adr_s;
        exp_t       e;
        @(negedge clk);
        rwc_s = bus.regwrite_cur;
        adr_s = bus.regwrite_adr_id;
        @(posedge clk);
        if (use_model && rwc_s) sb_cnt[adr_s] = sb_cnt[adr_s] + 3'd1;
        #1;
        if (use_model) begin
            for (int i = 0; i < 8; i++) ri[i] = sb_cnt[i];
        end
        reset                = rst_next;
        bus.id_valid         = v;
        bus.id_rs_used       = rsu;
        bus.id_rs_adr        = rs;
        bus.id_rt_used       = rtu;
        bus.id_rt_adr        = rt;
        bus.id_rd_adr        = rd;
        bus.id_regwrite      = rw;
        bus.id_is_load       = ld;
        bus.ex_ready         = exr;
        bus.flush            = fl;
        bus.register_invalid = ri;
        e.nm  = nm;
        e.iss = e_iss; e.stl = e_stl; e.rwc = e_rwc; e.fmm = e_fmm;
        e.adr = e_adr; e.st  = e_st;  e.stc = e_stc; e.hto = e_hto;
        exp_q.push_back(e);
    endtask

    // Reset cycle with an otherwise issuable instruction: every output must read zero.
    task automatic do_reset(input string nm);
        rst_next = 1'b1;
        cyc(nm, 1, 0, 0, 0, 0, 5, 1, 0, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0);
        rst_next = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.id_valid = 0; bus.id_rs_used = 0; bus.id_rs_adr = 0; bus.id_rt_used = 0;
        bus.id_rt_adr = 0; bus.id_rd_adr = 0; bus.id_regwrite = 0; bus.id_is_load = 0;
        bus.ex_ready = 0; bus.flush = 0; bus.register_invalid = '0;
        for (int i = 0; i < 8; i++) sb_cnt[i] = '0;

        // A: reset values, then a clean issue with a register write to r5.
        do_reset("a_rst");
        cyc("a_issue", 1, 1, 2, 0, 0, 5, 1, 0, 1, 0,  1, 0, 1, 0, 5,  0, 0, 0);

        // B: RAW on r3 for four cycles, then cleared; one bubble before issue.
        do_reset("b_rst");
        ri = '0; ri[3] = 3'd1;
        cyc("b_haz0", 1, 1, 3, 0, 0, 1, 1, 0, 1, 0,  0, 1, 0, 0, 0,  0, 0, 0);
        cyc("b_haz1", 1, 1, 3, 0, 0, 1, 1, 0, 1, 0,  0, 1, 0, 0, 0,  1, 1, 0);
        cyc("b_haz2", 1, 1, 3, 0, 0, 1, 1, 0, 1, 0,  0, 1, 0, 0, 0,  1, 2, 0);
        cyc("b_haz3", 1, 1, 3, 0, 0, 1, 1, 0, 1, 0,  0, 1, 0, 0, 0,  1, 3, 0);
        ri[3] = 3'd0;
        cyc("b_clr",  1, 1, 3, 0, 0, 1, 1, 0, 1, 0,  0, 1, 0, 0, 0,  1, 4, 0);
        cyc("b_iss",  1, 1, 3, 0, 0, 1, 1, 0, 1, 0,  1, 0, 1, 0, 1,  0, 5, 0);
        cyc("b_idle", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0,  0, 5, 0);

        // C: load to r4 with a live scoreboard model; dependent read stalls until writeback.
        do_reset("c_rst");
        ri = '0;
        use_model = 1'b1;
        cyc("c_load",   1, 0, 0, 0, 0, 4, 1, 1, 1, 0,  1, 0, 1, 1, 4,  0, 0, 0);
        cyc("c_dep0",   1, 1, 4, 0, 0, 2, 1, 0, 1, 0,  0, 1, 0, 0, 0,  0, 0, 0);
        cyc("c_dep1",   1, 1, 4, 0, 0, 2, 1, 0, 1, 0,  0, 1, 0, 0, 0,  1, 1, 0);
        sb_cnt[4] = sb_cnt[4] - 3'd1;
        cyc("c_wb",     1, 1, 4, 0, 0, 2, 1, 0, 1, 0,  0, 1, 0, 0, 0,  1, 2, 0);
        cyc("c_iss",    1, 1, 4, 0, 0, 2, 1, 0, 1, 0,  1, 0, 1, 0, 2,  0, 3, 0);
        cyc("c_dep_rt", 1, 0, 0, 1, 2, 0, 0, 0, 1, 0,  0, 1, 0, 0, 0,  0, 3, 0);
        use_model = 1'b0;

        // D: flush during HOLD, three DRAIN cycles; a second flush mid-drain restarts it.
        do_reset("d_rst");
        ri = '0; ri[3] = 3'd1;
        cyc("d_haz",     1, 1, 3, 0, 0, 1, 0, 0, 1, 0,  0, 1, 0, 0, 0,  0, 0, 0);
        cyc("d_hold",    1, 1, 3, 0, 0, 1, 0, 0, 1, 0,  0, 1, 0, 0, 0,  1, 1, 0);
        cyc("d_flush",   1, 1, 3, 0, 0, 1, 0, 0, 1, 1,  0, 1, 0, 0, 0,  1, 2, 0);
        ri[3] = 3'd0;
        cyc("d_drain0",  1, 1, 3, 0, 0, 1, 0, 0, 1, 0,  0, 1, 0, 0, 0,  2, 3, 0);
        cyc("d_drain1",  1, 1, 3, 0, 0, 1, 0, 0, 1, 0,  0, 1, 0, 0, 0,  2, 4, 0);
        cyc("d_drain2",  1, 1, 3, 0, 0, 1, 0, 0, 1, 0,  0, 1, 0, 0, 0,  2, 5, 0);
        cyc("d_run",     1, 1, 3, 0, 0, 1, 0, 0, 1, 0,  1, 0, 0, 0, 0,  0, 6, 0);
        cyc("d_flush2",  1, 1, 3, 0, 0, 1, 0, 0, 1, 1,  0, 1, 0, 0, 0,  0, 6, 0);
        cyc("d_dr0",     1, 1, 3, 0, 0, 1, 0, 0, 1, 0,  0, 1, 0, 0, 0,  2, 7, 0);
        cyc("d_reflush", 1, 1, 3, 0, 0, 1, 0, 0, 1, 1,  0, 1, 0, 0, 0,  2, 8, 0);
        cyc("d_dr1",     0, 1, 3, 0, 0, 1, 0, 0, 1, 0,  0, 1, 0, 0, 0,  2, 9, 0);
        cyc("d_dr2",     1, 1, 3, 0, 0, 1, 0, 0, 1, 0,  0, 1, 0, 0, 0,  2, 9, 0);
        cyc("d_dr3",     1, 1, 3, 0, 0, 1, 0, 0, 1, 0,  0, 1, 0, 0, 0,  2, 10, 0);
        cyc("d_run2",    1, 1, 3, 0, 0, 1, 0, 0, 1, 0,  1, 0, 0, 0, 0,  0, 11, 0);

        // E: destination saturation guard, register 0 not exempt, ex_ready low stays in RUN.
        do_reset("e_rst");
        ri = '0; ri[6] = 3'd7;
        cyc("e_sat",     1, 0, 0, 0, 0, 6, 1, 0, 1, 0,  0, 1, 0, 0, 0,  0, 0, 0);
        ri[6] = 3'd6;
        cyc("e_hold",    1, 0, 0, 0, 0, 6, 1, 0, 1, 0,  0, 1, 0, 0, 0,  1, 1, 0);
        cyc("e_iss6",    1, 0, 0, 0, 0, 6, 1, 0, 1, 0,  1, 0, 1, 0, 6,  0, 2, 0);
        ri[6] = 3'd7;
        cyc("e_norw",    1, 0, 0, 0, 0, 6, 0, 0, 1, 0,  1, 0, 0, 0, 0,  0, 2, 0);
        ri[0] = 3'd1;
        cyc("e_r0",      1, 1, 0, 0, 0, 6, 0, 0, 1, 0,  0, 1, 0, 0, 0,  0, 2, 0);
        cyc("e_r0_gone", 0, 1, 0, 0, 0, 6, 0, 0, 1, 0,  0, 0, 0, 0, 0,  1, 3, 0);
        ri[0] = 3'd0;
        cyc("e_exr0",    1, 0, 0, 0, 0, 6, 0, 0, 0, 0,  0, 1, 0, 0, 0,  0, 3, 0);
        cyc("e_exr0b",   1, 0, 0, 0, 0, 6, 0, 0, 0, 0,  0, 1, 0, 0, 0,  0, 4, 0);
        cyc("e_exr1",    1, 0, 0, 0, 0, 6, 0, 0, 1, 0,  1, 0, 0, 0, 0,  0, 5, 0);

        // F: watchdog with TIMEOUT=4; sticky until an async reset in the middle of HOLD.
        do_reset("f_rst0");
        ri = '0; ri[5] = 3'd1;
        cyc("f_h0",    1, 1, 5, 0, 0, 1, 0, 0, 1, 0,  0, 1, 0, 0, 0,  0, 0, 0);
        cyc("f_h1",    1, 1, 5, 0, 0, 1, 0, 0, 1, 0,  0, 1, 0, 0, 0,  1, 1, 0);
        cyc("f_h2",    1, 1, 5, 0, 0, 1, 0, 0, 1, 0,  0, 1, 0, 0, 0,  1, 2, 0);
        cyc("f_h3",    1, 1, 5, 0, 0, 1, 0, 0, 1, 0,  0, 1, 0, 0, 0,  1, 3, 0);
        cyc("f_h4",    1, 1, 5, 0, 0, 1, 0, 0, 1, 0,  0, 1, 0, 0, 0,  1, 4, 0);
        cyc("f_h5",    1, 1, 5, 0, 0, 1, 0, 0, 1, 0,  0, 1, 0, 0, 0,  1, 5, 1);
        ri[5] = 3'd0;
        cyc("f_clr",   1, 1, 5, 0, 0, 1, 0, 0, 1, 0,  0, 1, 0, 0, 0,  1, 6, 1);
        cyc("f_iss",   1, 1, 5, 0, 0, 1, 0, 0, 1, 0,  1, 0, 0, 0, 0,  0, 7, 1);
        ri[5] = 3'd1;
        cyc("f_re0",   1, 1, 5, 0, 0, 1, 0, 0, 1, 0,  0, 1, 0, 0, 0,  0, 7, 1);
        cyc("f_re1",   1, 1, 5, 0, 0, 1, 0, 0, 1, 0,  0, 1, 0, 0, 0,  1, 8, 1);
        do_reset("f_rst_hold");
        cyc("f_after", 1, 1, 5, 0, 0, 1, 0, 0, 1, 0,  0, 1, 0, 0, 0,  0, 0, 0);

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
